// File: rtl/det_stream_sched_if.sv
// Requester-side bus of det_stream_sched.
//   req      : per-requester request level
//   data     : requester i word at bits [i*WIDTH +: WIDTH]
//   gnt      : one-hot, one-cycle grant pulse
//   busy     : scheduler is not idle
//   done     : one-cycle report pulse
//   done_id  : requester index of the reported job
//   done_cnt : match count of the reported job
// master = requesting blocks, slave = scheduler.
interface det_stream_sched_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ID_W  = 1
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]       gnt;
  logic               busy;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic [CNT_W-1:0]   done_cnt;

  modport master (
    output req, data,
    input  gnt, busy, done, done_id, done_cnt
  );

  modport slave (
    input  req, data,
    output gnt, busy, done, done_id, done_cnt
  );
endinterface

// File: rtl/det_stream_sched.sv
// Round-robin scheduler sharing one serial 1101 Moore detector between N
// requesters. A granted word is shifted MSB-first onto det_in, followed by
// FLUSH_LEN zeros that return the detector to idle; detector match cycles are
// counted (saturating) and reported with the requester index.
//
// Ports:
//   clk     : rising-edge clock
//   rstn    : asynchronous active-low reset (shared with the detector)
//   bus     : requester bus (req/data in; gnt/busy/done/done_id/done_cnt out)
//   det_in  : registered serial bit to the detector
//   det_out : detector Moore match output
//   jobs_total, matches_total : 16-bit wrapping statistics, present only
//                               when DET_STREAM_SCHED_STATS_EN is defined
//
// Optional feature macro: DET_STREAM_SCHED_STATS_EN
module det_stream_sched #(
  parameter int unsigned N         = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FLUSH_LEN = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned ID_W      = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  det_stream_sched_if.slave       bus,
  output logic                    det_in,
  input  logic                    det_out
`ifdef DET_STREAM_SCHED_STATS_EN
  ,
  output logic [15:0]             jobs_total,
  output logic [15:0]             matches_total
`endif
);

  localparam int unsigned BIT_CW   = $clog2(WIDTH);
  localparam int unsigned FLUSH_CW = $clog2(FLUSH_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BIT_CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FLUSH_CW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 det_in_q, det_in_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;
`ifdef DET_STREAM_SCHED_STATS_EN
  logic [15:0]          jobs_q, jobs_d;
  logic [15:0]          matches_q, matches_d;
`endif

  logic                 found_hi, found_lo;
  logic [ID_W-1:0]      idx_hi, idx_lo;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [WIDTH-1:0]     grant_word;
  logic [CNT_W-1:0]     cnt_inc;

  // Round-robin pick: lowest requester at or above rr_q, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(i);
        if (ID_W'(i) >= rr_q) begin
          found_hi = 1'b1;
          idx_hi   = ID_W'(i);
        end
      end
    end
    grant_found = found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
    grant_word  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_word = bus.data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Saturating match count including the detector output seen at this edge.
  always_comb begin
    cnt_inc = cnt_q;
    if (det_out && !(&cnt_q)) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    gnt_d       = '0;
    det_in_d    = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    done_cnt_d  = done_cnt_q;
`ifdef DET_STREAM_SCHED_STATS_EN
    jobs_d      = jobs_q;
    matches_d   = matches_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d   = SHIFT;
          gnt_d     = N'(1) << grant_idx;
          // MSB goes out now; the register keeps the remaining bits.
          det_in_d  = grant_word[WIDTH-1];
          shift_d   = grant_word << 1;
          bit_cnt_d = '0;
          cnt_d     = '0;
          id_d      = grant_idx;
          rr_d      = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);
        end
      end

      SHIFT: begin
        cnt_d = cnt_inc;
        if (bit_cnt_q == BIT_CW'(WIDTH - 1)) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else begin
          det_in_d  = shift_q[WIDTH-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end

      FLUSH: begin
        cnt_d = cnt_inc;
        if (flush_cnt_q == FLUSH_CW'(FLUSH_LEN - 1)) begin
          state_d    = REPORT;
          done_d     = 1'b1;
          done_id_d  = id_q;
          done_cnt_d = cnt_inc;
`ifdef DET_STREAM_SCHED_STATS_EN
          jobs_d     = jobs_q + 16'd1;
          matches_d  = matches_q + 16'(cnt_inc);
`endif
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_CW'(1);
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      det_in_q    <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      done_cnt_q  <= '0;
`ifdef DET_STREAM_SCHED_STATS_EN
      jobs_q      <= '0;
      matches_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      det_in_q    <= det_in_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      done_cnt_q  <= done_cnt_d;
`ifdef DET_STREAM_SCHED_STATS_EN
      jobs_q      <= jobs_d;
      matches_q   <= matches_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.done_cnt = done_cnt_q;
  assign det_in       = det_in_q;
`ifdef DET_STREAM_SCHED_STATS_EN
  assign jobs_total    = jobs_q;
  assign matches_total = matches_q;
`endif

endmodule

// File: tb/tb_det_stream_sched.sv
// Bench for det_stream_sched: a default instance (N=2, WIDTH=8, FLUSH_LEN=4,
// CNT_W=4) and a second instance (N=3, WIDTH=12, FLUSH_LEN=2, CNT_W=1) for
// saturation and wrap-around arbitration. Each instance drives its own
// behavioural 1101 detector; expectations come from a round-robin pointer
// model and a window count over the MSB-first word.
module tb_det_stream_sched;

  localparam int unsigned N       = 2;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned FLUSH   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned JOB_LEN = WIDTH + FLUSH;

  localparam int unsigned N2      = 3;
  localparam int unsigned WIDTH2  = 12;
  localparam int unsigned FLUSH2  = 2;
  localparam int unsigned CNT_W2  = 1;
  localparam int unsigned ID_W2   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mdl_rr      = 0;
  int mdl_rr2     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default instance ----------------
  logic [N-1:0]       req_v;
  logic [N*WIDTH-1:0] data_v;
  logic               det_in, det_out;
  logic [3:0]         hist;

  det_stream_sched_if #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W), .ID_W(ID_W)) bus_if ();
  assign bus_if.req  = req_v;
  assign bus_if.data = data_v;

`ifdef DET_STREAM_SCHED_STATS_EN
  logic [15:0] jobs_total, matches_total, jobs_total2, matches_total2;
`endif

  det_stream_sched #(.N(N), .WIDTH(WIDTH), .FLUSH_LEN(FLUSH), .CNT_W(CNT_W), .ID_W(ID_W)) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus_if),
    .det_in        (det_in),
    .det_out       (det_out)
`ifdef DET_STREAM_SCHED_STATS_EN
    ,
    .jobs_total    (jobs_total),
    .matches_total (matches_total)
`endif
  );

  // Detector stand-in: Moore output is high when the last four inputs were 1101.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= '0;
    else       hist <= {hist[2:0], det_in};
  end
  assign det_out = (hist == 4'b1101);

  // ---------------- second instance ----------------
  logic [N2-1:0]        req2_v;
  logic [N2*WIDTH2-1:0] data2_v;
  logic                 det_in2, det_out2;
  logic [3:0]           hist2;

  det_stream_sched_if #(.N(N2), .WIDTH(WIDTH2), .CNT_W(CNT_W2), .ID_W(ID_W2)) bus2_if ();
  assign bus2_if.req  = req2_v;
  assign bus2_if.data = data2_v;

  det_stream_sched #(.N(N2), .WIDTH(WIDTH2), .FLUSH_LEN(FLUSH2), .CNT_W(CNT_W2), .ID_W(ID_W2)) u_dut2 (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus2_if),
    .det_in        (det_in2),
    .det_out       (det_out2)
`ifdef DET_STREAM_SCHED_STATS_EN
    ,
    .jobs_total    (jobs_total2),
    .matches_total (matches_total2)
`endif
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist2 <= '0;
    else       hist2 <= {hist2[2:0], det_in2};
  end
  assign det_out2 = (hist2 == 4'b1101);

  // ---------------- reference helpers ----------------
  function automatic int exp_matches(input logic [31:0] word, input int w, input int cw);
    int n;
    int sat;
    n   = 0;
    sat = (1 << cw) - 1;
    for (int j = 3; j < w; j++) begin
      if (word[w-1-(j-3)] && word[w-1-(j-2)] && !word[w-1-(j-1)] && word[w-1-j]) n++;
    end
    return (n > sat) ? sat : n;
  endfunction

  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
    for (int i = 0; i < n; i++) begin
      int cand;
      cand = (ptr + i) % n;
      if (req[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full job on the default instance, starting from an IDLE sample point.
  task automatic run_job(input bit gap_chk, input int prev_cyc, input bit drop,
                         output int gnt_cyc, output int waited);
    logic [N-1:0]     g;
    logic [WIDTH-1:0] word;
    int               exp_idx;
    int               ecnt;
    bit               got;
    got     = 1'b0;
    waited  = 0;
    gnt_cyc = prev_cyc;
    g       = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus_if.gnt !== '0) begin
        got    = 1'b1;
        waited = c;
        g      = bus_if.gnt;
        break;
      end
    end
    if (!got) begin
      chk("gnt_timeout", 32'(g), 32'(1));
      return;
    end
    gnt_cyc = cyc;
    exp_idx = rr_pick(32'(req_v), mdl_rr, int'(N));
    if (exp_idx < 0) exp_idx = 0;
    chk("gnt_onehot", 32'(g), 32'(1) << exp_idx);
    if (gap_chk) chk("gnt_gap", 32'(gnt_cyc - prev_cyc), 32'(JOB_LEN + 2));
    mdl_rr = (exp_idx + 1) % int'(N);
    word   = data_v[exp_idx*WIDTH +: WIDTH];
    ecnt   = exp_matches(32'(word), int'(WIDTH), int'(CNT_W));
    if (drop) req_v[exp_idx] = 1'b0;

    for (int k = 0; k < int'(JOB_LEN); k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 1) chk("gnt_width", 32'(bus_if.gnt), 32'(0));
      end
      chk("det_in_seq", 32'(det_in), (k < int'(WIDTH)) ? 32'(word[int'(WIDTH)-1-k]) : 32'(0));
      chk("busy_job", 32'(bus_if.busy), 32'(1));
      chk("done_early", 32'(bus_if.done), 32'(0));
    end

    @(posedge clk); #1;
    chk("done_pulse", 32'(bus_if.done), 32'(1));
    chk("done_id", 32'(bus_if.done_id), 32'(exp_idx));
    chk("done_cnt", 32'(bus_if.done_cnt), 32'(ecnt));
    chk("busy_report", 32'(bus_if.busy), 32'(1));
    chk("det_in_report", 32'(det_in), 32'(0));

    @(posedge clk); #1;
    chk("done_fall", 32'(bus_if.done), 32'(0));
    chk("busy_idle", 32'(bus_if.busy), 32'(0));
    chk("hold_id", 32'(bus_if.done_id), 32'(exp_idx));
    chk("hold_cnt", 32'(bus_if.done_cnt), 32'(ecnt));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    int waited;
    int exp2;
    int ecnt2;
    int gc2;
    int lat;
    bit got2;
    logic [N2-1:0] g2;
    logic [WIDTH2-1:0] w2;

    // Step 1: reset with both requests held.
    req_v   = 2'b11;
    data_v  = {8'b0000_0000, 8'b1101_0000};
    req2_v  = '0;
    data2_v = '0;
    #2 rstn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      chk("rst_det_in", 32'(det_in), 32'(0));
      chk("rst_gnt", 32'(bus_if.gnt), 32'(0));
      chk("rst_busy", 32'(bus_if.busy), 32'(0));
      chk("rst_done", 32'(bus_if.done), 32'(0));
    end
    chk("rst_done_id", 32'(bus_if.done_id), 32'(0));
    chk("rst_done_cnt", 32'(bus_if.done_cnt), 32'(0));
    mdl_rr  = 0;
    mdl_rr2 = 0;
    rstn    = 1'b1;

    // Step 2: requester 0 granted first, word 1101_0000.
    run_job(1'b0, 0, 1'b1, gc, waited);
    chk("first_gnt_latency", 32'(waited), 32'(1));

    // Step 3: requester 1 alone, zero word.
    run_job(1'b1, gc, 1'b1, gc, waited);

    // Step 4: both held continuously for four jobs.
    data_v = {8'b1101_1011, 8'h6D};
    req_v  = 2'b11;
    for (int j = 0; j < 4; j++) run_job(1'b1, gc, 1'b0, gc, waited);

    // Step 5: randomized requests and words.
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_v[i]) begin
          data_v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_v[i] = 1'($urandom);
        end
      end
      if (req_v == '0) req_v[$urandom_range(int'(N) - 1, 0)] = 1'b1;
      run_job(1'b1, gc, 1'($urandom), gc, waited);
    end
    req_v = '0;

    // Step 6: reset in the middle of SHIFT.
    data_v = {8'h00, 8'hFF};
    req_v  = 2'b01;
    got2   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus_if.gnt !== '0) begin got2 = 1'b1; break; end
    end
    chk("mid_gnt_seen", 32'(got2), 32'(1));
    req_v = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    chk("mid_rst_det_in", 32'(det_in), 32'(0));
    chk("mid_rst_busy", 32'(bus_if.busy), 32'(0));
`ifdef DET_STREAM_SCHED_STATS_EN
    chk("stats_jobs_rst", 32'(jobs_total), 32'(0));
    chk("stats_matches_rst", 32'(matches_total), 32'(0));
`endif
    mdl_rr  = 0;
    mdl_rr2 = 0;
    req_v   = 2'b11;
    data_v  = {8'b0110_1101, 8'b1011_0100};
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk("mid_rst_done", 32'(bus_if.done), 32'(0));
      chk("mid_rst_gnt", 32'(bus_if.gnt), 32'(0));
    end
    rstn = 1'b1;
    run_job(1'b0, 0, 1'b1, gc, waited);
    chk("post_rst_latency", 32'(waited), 32'(1));
`ifdef DET_STREAM_SCHED_STATS_EN
    chk("stats_jobs", 32'(jobs_total), 32'(1));
    chk("stats_matches", 32'(matches_total), 32'(exp_matches(32'(8'b1011_0100), int'(WIDTH), int'(CNT_W))));
`endif
    req_v = '0;
    repeat (JOB_LEN + 4) begin @(posedge clk); #1; end

    // Step 7: WIDTH=12, CNT_W=1 instance, three requesters, wrap-around order.
    data2_v = {12'b1101_1101_1101, 12'b0000_1111_0000, 12'b1101_0110_1000};
    data2_v = {data2_v[WIDTH2-1:0], data2_v[3*WIDTH2-1:WIDTH2]};
    req2_v  = 3'b111;
    mdl_rr2 = 1;
    req2_v  = 3'b110;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) req2_v[0] = 1'b1;
      got2 = 1'b0;
      g2   = '0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (bus2_if.gnt !== '0) begin got2 = 1'b1; g2 = bus2_if.gnt; break; end
      end
      chk("w12_gnt_seen", 32'(got2), 32'(1));
      exp2 = rr_pick(32'(req2_v), (j == 0) ? 0 : mdl_rr2, int'(N2));
      if (exp2 < 0) exp2 = 0;
      chk("w12_gnt", 32'(g2), 32'(1) << exp2);
      mdl_rr2 = (exp2 + 1) % int'(N2);
      w2      = data2_v[exp2*WIDTH2 +: WIDTH2];
      ecnt2   = exp_matches(32'(w2), int'(WIDTH2), int'(CNT_W2));
      req2_v[exp2] = 1'b0;
      gc2 = cyc;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (bus2_if.done === 1'b1) begin lat = c; break; end
        chk("w12_busy", 32'(bus2_if.busy), 32'(1));
      end
      chk("w12_done_latency", 32'(lat), 32'(WIDTH2 + FLUSH2));
      chk("w12_done_id", 32'(bus2_if.done_id), 32'(exp2));
      chk("w12_done_cnt", 32'(bus2_if.done_cnt), 32'(ecnt2));
      if (gc2 < 0) chk("w12_cycle", 32'(gc2), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/det_stream_sched.md
Name: det_stream_sched

Overview:
- Round-robin scheduler sharing one serial 1101 Moore sequence detector between N requesters.
- Each requester presents a parallel WIDTH-bit word. The scheduler grants one requester and serialises its word MSB-first onto the detector input.
- It then drives flush zeros to return the detector to its idle state, counts detector match cycles, and reports the count with the requester ID.
- Sits between the requesting blocks and the detector instance; it is the only driver of the detector's serial input.

Parameters:
N, 2, number of requesters (2..8)
WIDTH, 8, bits per word (>= 4)
FLUSH_LEN, 4, zero cycles driven after each word (>= 2)
CNT_W, 4, match counter width; saturates at all-ones
ID_W, 1, requester index width (clog2(N), minimum 1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
req  input  N  per-requester request level; held until matching gnt bit seen
data  input  N*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]; stable while req[i]=1
gnt  output  N  one-hot, one-cycle registered grant pulse
busy  output  1  high in any state other than IDLE
det_in  output  1  registered serial bit to detector
det_out  input  1  detector Moore match output
done  output  1  one-cycle report pulse
done_id  output  ID_W  requester index of reported job; valid with done
done_cnt  output  CNT_W  match count of reported job; valid with done

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; gnt=0, busy=0, det_in=0, done=0, done_id=0, done_cnt=0; rr pointer=0; shift register, bit and flush counters cleared.
- States: IDLE, SHIFT, FLUSH, REPORT.
- IDLE: det_in=0. If req!=0 at a rising edge:
  - pick the first set req bit searching from rr pointer upward, wrapping;
  - register gnt one-hot for exactly one cycle;
  - latch data slice into shift register and grant index into an ID register;
  - det_in<=MSB, match counter<=0, state->SHIFT;
  - rr pointer<=granted index+1 mod N.
- SHIFT: lasts WIDTH cycles; det_in presents bit WIDTH-1 down to 0, one per cycle. After last bit -> FLUSH with det_in<=0.
- FLUSH: det_in=0 for FLUSH_LEN cycles, then -> REPORT.
- Match counting: on every rising edge while in SHIFT or FLUSH, if det_out=1, counter increments.
  - Saturates at 2^CNT_W-1, no wrap.
  - Flush guarantees det_out=0 on the first SHIFT edge, so no mask is needed.
- REPORT: done=1 for this single cycle, with done_id and done_cnt driven from registers. Next state IDLE. No arbitration in REPORT.
- Latency:
  - gnt high in first SHIFT cycle.
  - done rises WIDTH+FLUSH_LEN cycles after gnt.
  - Minimum spacing between grants is WIDTH+FLUSH_LEN+2 cycles.
- Requester rules:
  - req sampled only in IDLE; a requester dropping req before grant is simply skipped.
  - Requester must deassert req in the cycle it observes gnt, or it is eligible again next IDLE.
- Simultaneous requests: exactly one grant per IDLE edge; rr order guarantees no starvation (each pending requester served within N jobs).
- Reset mid-job: job is discarded, no done pulse, det_in returns to 0 immediately. Detector shares rstn.
- done_id/done_cnt hold their last values between done pulses.

Optional Feature:
DET_STREAM_SCHED_STATS_EN
- Defined: adds outputs jobs_total (16 bits) and matches_total (16 bits).
  - jobs_total increments on each done pulse.
  - matches_total adds done_cnt on each done pulse.
  - Both wrap modulo 2^16; both reset to 0 under rstn.
- Undefined: ports and registers absent; all other behaviour identical.

Test Plan:
1. Reset with req=2'b11 held, release rstn -> first gnt=2'b01 one cycle after release edge; det_in=0 throughout reset.
2. N=2, WIDTH=8, FLUSH_LEN=4. req[0] with data 8'b1101_0000 -> det_in sequence 1,1,0,1,0,0,0,0 then four 0s; done 12 cycles after gnt with done_id=0, done_cnt=1.
3. req[1] only, data 8'b0000_0000 -> done_id=1, done_cnt=0; busy high from gnt through the done cycle.
4. Both requesters held continuously for 4 jobs -> grant order 0,1,0,1; consecutive gnt pulses exactly 14 cycles apart.
5. WIDTH=12 build, word 12'b1101_0110_1000 -> done_cnt=2. With CNT_W=1 and the same word -> done_cnt=1 (saturated).
6. Assert rstn=0 midway through SHIFT -> no done pulse, state IDLE, rr pointer 0. A new request after release is granted normally; with STATS_EN defined, jobs_total=0 after the reset.
